pc_stack_unit: RTL
==================

// Module: pc_stack_unit
// PURPOSE
//  Parametrised program-counter sequencer with a circular hardware call/return
//  stack for the CPU datapath. Each cycle that advance is high, it applies one
//  op: increment, skip, goto, call or return. Stack over/underflow are reported
//  through sticky flags. Drives the instruction-memory address; the decoder
//  supplies op, target and page.
// PARAMETERS
//  PC_W       13  program counter width
//  TGT_W      11  jump target field width from instruction
//  PAGE_W      2  page bits prepended to target; PAGE_W+TGT_W == PC_W (elab check)
//  STK_DEPTH   8  return stack entries, power of 2, >= 2
//  RESET_VEC   0  PC value and stack-entry value after reset
// PORTS
//  clk          in   1                clock, rising edge
//  reset_n      in   1                asynchronous reset, active-low
//  advance      in   1                1 = execute op this cycle; 0 = hold all state
//  op           in   3                pc_op_t: NEXT=0 SKIP=1 GOTO=2 CALL=3 RETURN=4; 5-7 = NEXT
//  target       in   TGT_W            goto/call target low bits
//  page_sel     in   PAGE_W           goto/call target high bits
//  clr_err      in   1                clear sticky ovf/unf flags
//  pc           out  PC_W             current fetch address
//  top          out  PC_W             entry at top of stack (stack[ptr-1])
//  depth        out  $clog2(DEPTH+1)  valid entries, saturates at STK_DEPTH
//  full         out  1                depth == STK_DEPTH
//  empty        out  1                depth == 0
//  stk_ovf      out  1                sticky: a CALL was made while full
//  stk_unf      out  1                sticky: a RETURN was made while empty
// BEHAVIOUR
//  - Reset (async, reset_n=0): pc=RESET_VEC, ptr=0, depth=0, all stack
//    entries=RESET_VEC, stk_ovf=stk_unf=0. Takes effect immediately, even
//    mid-operation; the first op executes on the first rising edge after
//    release.
//  - All updates are registered. pc changes one cycle after the edge that
//    samples the op (single-cycle latency). Outputs are driven by flops.
//  - advance=0: pc, ptr, depth, stack and flags hold. clr_err is still honoured.
//  - NEXT:   pc <= pc+1, modulo 2^PC_W (0x1FFF -> 0x0000 at default widths).
//  - SKIP:   pc <= pc+2, modulo 2^PC_W (0x1FFF -> 0x0001).
//  - GOTO:   pc <= {page_sel,target}. Stack is unchanged.
//  - CALL:   stack[ptr] <= pc+1 (wrapped), ptr <= ptr+1 mod STK_DEPTH,
//            pc <= {page_sel,target}, depth <= min(depth+1, STK_DEPTH).
//            If full before the call: the oldest entry is overwritten
//            (circular), depth stays STK_DEPTH and stk_ovf <= 1.
//  - RETURN: pc <= stack[ptr-1], ptr <= ptr-1 mod STK_DEPTH,
//            depth <= depth-1. If empty before the return: pc still loads
//            the wrapped entry stack[ptr-1], ptr still decrements, depth
//            stays 0 and stk_unf <= 1.
//  - Flags: if clr_err and a new ovf/unf event occur in the same cycle, the
//    set wins. Otherwise clr_err clears both flags on the next edge.
//  - top is combinational from the registered ptr and stack (read mux only).
//  - full and empty are decoded from depth. They are never both 1.
// STRUCTURE
//  - pc_stack_pkg: typedef enum logic [2:0] pc_op_t {PC_NEXT, PC_SKIP,
//    PC_GOTO, PC_CALL, PC_RETURN}; localparam helpers for depth width.
//  - Sub-module call_stack: circular LIFO (STK_DEPTH x PC_W) holding ptr,
//    depth, full/empty and ovf/unf event pulses. Inputs are push, pop and
//    wdata; outputs are top and the status signals. pc_stack_unit holds the
//    pc register, the next-pc mux and the sticky flags.
// TESTING
//  1 Reset, then 5 cycles of NEXT -> pc 0,1,2,3,4,5; depth=0, empty=1.
//  2 pc=0x0010, CALL page=1 tgt=0x123 -> pc=0x0923, top=0x0011, depth=1;
//    then RETURN -> pc=0x0011, empty=1.
//  3 Nine nested CALLs from distinct pcs -> full after 8 calls; 9th sets
//    stk_ovf=1 with depth=8; eight RETURNs yield return addresses 9..2
//    (the first was overwritten).
//  4 From empty, RETURN -> stk_unf=1, depth=0, pc=wrapped entry; clr_err
//    with no event -> both flags 0.
//  5 pc=0x1FFF: NEXT -> 0x0000; from 0x1FFF, SKIP -> 0x0001.
//    advance=0 with op=CALL -> no change to any state.
//  6 Assert reset_n low between clock edges during a CALL sequence -> pc,
//    depth and flags clear immediately; the stack reads RESET_VEC after
//    release.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// rtl/pc_stack_pkg.sv - op encoding and sizing helpers shared by the pc sequencer and its return stack
package pc_stack_pkg;

  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_SKIP   = 3'd1,
    PC_GOTO   = 3'd2,
    PC_CALL   = 3'd3,
    PC_RETURN = 3'd4
  } pc_op_t;

  // Width of a counter that must reach depth itself (0..depth inclusive).
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a circular index into depth entries; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/call_stack.sv
// rtl/call_stack.sv - circular return-address LIFO with saturating depth and over/underflow event pulses
module call_stack
  import pc_stack_pkg::*;
#(
  parameter int              DATA_W    = 13,
  parameter int              DEPTH     = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         top,
  output logic [cnt_w(DEPTH)-1:0]   depth,
  output logic                      full,
  output logic                      empty,
  output logic                      ovf_evt,
  output logic                      unf_evt
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;

  // DEPTH is a power of two, so plain binary wrap gives the circular index.
  assign ptr_inc = ptr + PTR_W'(1);
  assign ptr_dec = ptr - PTR_W'(1);

  assign top   = mem[ptr_dec];
  assign full  = (depth == CNT_MAX);
  assign empty = (depth == '0);

  // Push wins if both are ever requested together; the sequencer never does that.
  assign ovf_evt = push & full;
  assign unf_evt = pop & ~push & empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (push) begin
      mem[ptr] <= wdata;
      ptr      <= ptr_inc;
      if (!full) begin
        depth <= depth + CNT_W'(1);
      end
    end else if (pop) begin
      ptr <= ptr_dec;
      if (!empty) begin
        depth <= depth - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program-counter sequencer: next-pc mux, pc register and sticky stack error flags
module pc_stack_unit
  import pc_stack_pkg::*;
#(
  parameter int PC_W      = 13,
  parameter int TGT_W     = 11,
  parameter int PAGE_W    = 2,
  parameter int STK_DEPTH = 8,
  parameter int RESET_VEC = 0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               advance,
  input  logic [2:0]                         op,
  input  logic [TGT_W-1:0]                   target,
  input  logic [PAGE_W-1:0]                  page_sel,
  input  logic                               clr_err,
  output logic [PC_W-1:0]                    pc,
  output logic [PC_W-1:0]                    top,
  output logic [$clog2(STK_DEPTH+1)-1:0]     depth,
  output logic                               full,
  output logic                               empty,
  output logic                               stk_ovf,
  output logic                               stk_unf
);

  localparam logic [PC_W-1:0] RST_PC = RESET_VEC[PC_W-1:0];

  if (PAGE_W + TGT_W != PC_W) begin : g_bad_target_width
    $error("pc_stack_unit: PAGE_W + TGT_W must equal PC_W");
  end
  if (!is_pow2(STK_DEPTH) || STK_DEPTH < 2) begin : g_bad_depth
    $error("pc_stack_unit: STK_DEPTH must be a power of two and at least 2");
  end

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_skip;
  logic [PC_W-1:0] pc_jump;
  logic [PC_W-1:0] pc_next;
  logic            push;
  logic            pop;
  logic            ovf_evt;
  logic            unf_evt;

  assign pc_inc  = pc + PC_W'(1);
  assign pc_skip = pc + PC_W'(2);
  assign pc_jump = {page_sel, target};

  // Undefined op codes 5..7 fall through to NEXT.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    if (advance) begin
      case (op)
        PC_SKIP:   pc_next = pc_skip;
        PC_GOTO:   pc_next = pc_jump;
        PC_CALL: begin
          pc_next = pc_jump;
          push    = 1'b1;
        end
        PC_RETURN: begin
          pc_next = top;
          pop     = 1'b1;
        end
        default:   pc_next = pc_inc;
      endcase
    end
  end

  call_stack #(
    .DATA_W    (PC_W),
    .DEPTH     (STK_DEPTH),
    .RESET_VAL (RST_PC)
  ) u_call_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (pc_inc),
    .top     (top),
    .depth   (depth),
    .full    (full),
    .empty   (empty),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  // A new event on a flag beats a simultaneous clear of that same flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= RST_PC;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      pc <= pc_next;
      if (ovf_evt) begin
        stk_ovf <= 1'b1;
      end else if (clr_err) begin
        stk_ovf <= 1'b0;
      end
      if (unf_evt) begin
        stk_unf <= 1'b1;
      end else if (clr_err) begin
        stk_unf <= 1'b0;
      end
    end
  end

endmodule
